// File: rtl/intcode_io_fifo_port.sv
// Memory-mapped FIFO I/O responder for the intcode CPU bus: host-fed input FIFO, host-drained output FIFO.
// Define INTCODE_IO_STATUS_EN to decode STAT_ADDR (status read, sticky-flag clear on write).
module intcode_io_fifo_port #(
    parameter int          DEPTH       = 8,
    parameter logic [31:0] IN_ADDR     = 32'hFFFF_0000,
    parameter logic [31:0] OUT_ADDR    = 32'hFFFF_0001,
    parameter logic [31:0] STAT_ADDR   = 32'hFFFF_0002,
    parameter logic [31:0] EMPTY_VALUE = 32'h0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [31:0]              address_bus,
    input  logic                     ram_write,
    inout  wire  [31:0]              data_bus,
    input  logic [31:0]              in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [31:0]              out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   in_count,
    output logic [$clog2(DEPTH):0]   out_count
);

    localparam int            AW         = $clog2(DEPTH);
    localparam int            CW         = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [31:0]   r_inMem  [DEPTH];
    logic [AW-1:0] r_inRd;
    logic [AW-1:0] r_inWr;
    logic [CW-1:0] r_inCount;
    logic [31:0]   r_outMem [DEPTH];
    logic [AW-1:0] r_outRd;
    logic [AW-1:0] r_outWr;
    logic [CW-1:0] r_outCount;
    logic          r_matchQ;
    logic          r_wrHitQ;
    logic          r_overflow;
    logic          r_underflow;

    logic          w_inMatch;
    logic          w_wrHit;
    logic          w_inEmpty;
    logic          w_inFull;
    logic          w_outEmpty;
    logic          w_outFull;
    logic          w_inPush;
    logic          w_inPop;
    logic          w_accessEnd;
    logic          w_underflowEvt;
    logic          w_outPush;
    logic          w_outPop;
    logic          w_wrRise;
    logic          w_overflowEvt;
    logic          w_stickyClear;
    logic          w_drive;
    logic [31:0]   w_driveData;
    logic [31:0]   w_inHead;

    assign w_inMatch  = (address_bus == IN_ADDR) && !ram_write;
    assign w_wrHit    = (address_bus == OUT_ADDR) && ram_write;
    assign w_inEmpty  = (r_inCount == '0);
    assign w_inFull   = (r_inCount == FULL_COUNT);
    assign w_outEmpty = (r_outCount == '0);
    assign w_outFull  = (r_outCount == FULL_COUNT);

    assign in_ready = !w_inFull;
    assign w_inPush = in_valid && !w_inFull;

    // A CPU read consumes the head only once the access ends, so a held address sees a stable word.
    assign w_accessEnd    = r_matchQ && !w_inMatch;
    assign w_inPop        = w_accessEnd && !w_inEmpty;
    assign w_underflowEvt = w_accessEnd && w_inEmpty;

    assign out_valid = !w_outEmpty;
    assign w_outPop  = out_valid && out_ready;
    assign w_wrRise  = w_wrHit && !r_wrHitQ;

    // A same-edge host pop frees the slot, so a write into a full FIFO is still accepted then.
    assign w_outPush     = w_wrRise && (!w_outFull || w_outPop);
    assign w_overflowEvt = w_wrRise && w_outFull && !w_outPop;

    assign out_data  = w_outEmpty ? 32'h0 : r_outMem[r_outRd];
    assign in_count  = r_inCount;
    assign out_count = r_outCount;
    assign w_inHead  = w_inEmpty ? EMPTY_VALUE : r_inMem[r_inRd];

`ifdef INTCODE_IO_STATUS_EN
    logic w_statRead;
    logic w_statWrite;
    logic r_statWrQ;

    assign w_statRead    = (address_bus == STAT_ADDR) && !ram_write;
    assign w_statWrite   = (address_bus == STAT_ADDR) && ram_write;
    assign w_stickyClear = w_statWrite && !r_statWrQ;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_statWrQ <= 1'b0;
        else       r_statWrQ <= w_statWrite;
    end

    always_comb begin
        w_drive     = 1'b0;
        w_driveData = 32'h0;
        if (!reset && w_inMatch) begin
            w_drive     = 1'b1;
            w_driveData = w_inHead;
        end else if (!reset && w_statRead) begin
            w_drive     = 1'b1;
            w_driveData = {26'b0, r_overflow, r_underflow, w_outFull, w_outEmpty, w_inFull, w_inEmpty};
        end
    end
`else
    assign w_stickyClear = 1'b0;

    always_comb begin
        w_drive     = 1'b0;
        w_driveData = 32'h0;
        if (!reset && w_inMatch) begin
            w_drive     = 1'b1;
            w_driveData = w_inHead;
        end
    end
`endif

    assign data_bus = w_drive ? w_driveData : 32'bz;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_inRd      <= '0;
            r_inWr      <= '0;
            r_inCount   <= '0;
            r_outRd     <= '0;
            r_outWr     <= '0;
            r_outCount  <= '0;
            r_matchQ    <= 1'b0;
            r_wrHitQ    <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_matchQ <= w_inMatch;
            r_wrHitQ <= w_wrHit;
            if (w_inPush)  r_inWr  <= r_inWr + 1'b1;
            if (w_inPop)   r_inRd  <= r_inRd + 1'b1;
            if (w_outPush) r_outWr <= r_outWr + 1'b1;
            if (w_outPop)  r_outRd <= r_outRd + 1'b1;
            r_inCount   <= r_inCount + {{AW{1'b0}}, w_inPush} - {{AW{1'b0}}, w_inPop};
            r_outCount  <= r_outCount + {{AW{1'b0}}, w_outPush} - {{AW{1'b0}}, w_outPop};
            r_overflow  <= (r_overflow & ~w_stickyClear) | w_overflowEvt;
            r_underflow <= (r_underflow & ~w_stickyClear) | w_underflowEvt;
        end
    end

    // Storage needs no reset: occupancy and pointers alone decide what is visible.
    always_ff @(posedge clock) begin
        if (w_inPush)  r_inMem[r_inWr]   <= in_data;
        if (w_outPush) r_outMem[r_outWr] <= data_bus;
    end

endmodule

// File: tb/tb_intcode_io_fifo_port.sv
// Randomised scoreboard bench for intcode_io_fifo_port: queue-based reference model, negedge monitor.
// Status-register checks are included when INTCODE_IO_STATUS_EN is defined.
module tb_intcode_io_fifo_port;

    localparam int          DEPTH       = 8;
    localparam logic [31:0] IN_ADDR     = 32'hFFFF_0000;
    localparam logic [31:0] OUT_ADDR    = 32'hFFFF_0001;
    localparam logic [31:0] STAT_ADDR   = 32'hFFFF_0002;
    localparam logic [31:0] EMPTY_VALUE = 32'h0000_DEAD;

    typedef enum int {BUS_DONTCARE, BUS_VALUE, BUS_RELEASED} busmode_e;

    typedef struct {
        int          inCnt;
        int          outCnt;
        bit          inRdy;
        bit          outVld;
        logic [31:0] outData;
        busmode_e    busMode;
        logic [31:0] busVal;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] address_bus;
    logic        ram_write;
    wire  [31:0] data_bus;
    logic [31:0] cpuData;
    logic        cpuDrive;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  in_count;
    logic [3:0]  out_count;

    logic [31:0] mdlIn[$];
    logic [31:0] mdlOut[$];
    bit          mdlUnder;
    bit          mdlOver;
    bit          mdlAccess;
    bit          mdlWrHeld;
`ifdef INTCODE_IO_STATUS_EN
    bit          mdlStatHeld;
`endif

    exp_t        expQ[$];
    logic [31:0] expOut[$];
    exp_t        monExp;
    int          checks   = 0;
    int          failures = 0;

    intcode_io_fifo_port #(
        .DEPTH(DEPTH), .IN_ADDR(IN_ADDR), .OUT_ADDR(OUT_ADDR),
        .STAT_ADDR(STAT_ADDR), .EMPTY_VALUE(EMPTY_VALUE)
    ) dut (
        .clock(clock), .reset(reset), .address_bus(address_bus), .ram_write(ram_write),
        .data_bus(data_bus), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .in_count(in_count), .out_count(out_count)
    );

    assign data_bus = cpuDrive ? cpuData : 32'bz;

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Undriven bus reads as z on four-state simulators and 0 on two-state ones.
    task automatic checkReleased();
        checks++;
        if (!(data_bus === 32'bz || data_bus === 32'h0)) begin
            failures++;
            $display("[TB] FAIL data_bus_release: got %h, expected z at %0t", data_bus, $time);
        end
    endtask

    function automatic logic [31:0] statusWord();
        logic [31:0] s;
        s    = 32'h0;
        s[0] = (mdlIn.size() == 0);
        s[1] = (mdlIn.size() == DEPTH);
        s[2] = (mdlOut.size() == 0);
        s[3] = (mdlOut.size() == DEPTH);
        s[4] = mdlUnder;
        s[5] = mdlOver;
        return s;
    endfunction

    // Drives one cycle of inputs, queues the expected visible state, then advances the model by one edge.
    task automatic applyStimulus(input logic [31:0] addr, input logic rw, input logic [31:0] wdata,
                                 input logic inV, input logic [31:0] inD, input logic outR);
        exp_t e;
        bit   inMatch;
        bit   wrHit;
        address_bus = addr;
        ram_write   = rw;
        cpuData     = wdata;
        cpuDrive    = rw;
        in_valid    = inV;
        in_data     = inD;
        out_ready   = outR;

        inMatch   = (addr == IN_ADDR) && !rw;
        wrHit     = (addr == OUT_ADDR) && rw;
        e.inCnt   = mdlIn.size();
        e.outCnt  = mdlOut.size();
        e.inRdy   = (mdlIn.size() < DEPTH);
        e.outVld  = (mdlOut.size() != 0);
        e.outData = (mdlOut.size() != 0) ? mdlOut[0] : 32'h0;
        e.busVal  = 32'h0;
        if (inMatch) begin
            e.busMode = BUS_VALUE;
            e.busVal  = (mdlIn.size() != 0) ? mdlIn[0] : EMPTY_VALUE;
        end
`ifdef INTCODE_IO_STATUS_EN
        else if (addr == STAT_ADDR && !rw) begin
            e.busMode = BUS_VALUE;
            e.busVal  = statusWord();
        end
`endif
        else if (!rw) e.busMode = BUS_RELEASED;
        else          e.busMode = BUS_DONTCARE;
        expQ.push_back(e);

`ifdef INTCODE_IO_STATUS_EN
        if (addr == STAT_ADDR && rw && !mdlStatHeld) begin
            mdlUnder = 0;
            mdlOver  = 0;
        end
        mdlStatHeld = (addr == STAT_ADDR) && rw;
`endif
        if (inV && mdlIn.size() < DEPTH) begin
            if (mdlAccess && !inMatch) begin
                if (mdlIn.size() == 0) mdlUnder = 1;
                else void'(mdlIn.pop_front());
            end
            mdlIn.push_back(inD);
        end else if (mdlAccess && !inMatch) begin
            if (mdlIn.size() == 0) mdlUnder = 1;
            else void'(mdlIn.pop_front());
        end
        if (outR && mdlOut.size() != 0) void'(mdlOut.pop_front());
        if (wrHit && !mdlWrHeld) begin
            if (mdlOut.size() < DEPTH) begin
                mdlOut.push_back(wdata);
                expOut.push_back(wdata);
            end else begin
                mdlOver = 1;
            end
        end
        mdlAccess = inMatch;
        mdlWrHeld = wrHit;
        @(posedge clock);
        #1;
    endtask

    task automatic doReset(input logic [31:0] addr);
        exp_t e;
        address_bus = addr;
        ram_write   = 1'b0;
        cpuDrive    = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        reset       = 1'b1;
        mdlIn.delete();
        mdlOut.delete();
        expOut.delete();
        mdlUnder  = 0;
        mdlOver   = 0;
        mdlAccess = 0;
        mdlWrHeld = 0;
`ifdef INTCODE_IO_STATUS_EN
        mdlStatHeld = 0;
`endif
        e.inCnt   = 0;
        e.outCnt  = 0;
        e.inRdy   = 1;
        e.outVld  = 0;
        e.outData = 32'h0;
        e.busMode = BUS_RELEASED;
        e.busVal  = 32'h0;
        expQ.push_back(e);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic cpuRead(input logic [31:0] addr, input int n);
        for (int i = 0; i < n; i++) applyStimulus(addr, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic cpuWrite(input logic [31:0] addr, input logic [31:0] d, input int n);
        for (int i = 0; i < n; i++) applyStimulus(addr, 1'b1, d, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic hostPush(input logic [31:0] d);
        applyStimulus(32'h0, 1'b0, 32'h0, 1'b1, d, 1'b0);
    endtask

    task automatic hostPop(input int n);
        for (int i = 0; i < n; i++) applyStimulus(32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    endtask

    // Monitor: one queued expectation per cycle, plus an output-word scoreboard on each host handshake.
    always @(negedge clock) begin
        if (expQ.size() > 0) begin
            monExp = expQ.pop_front();
            checkOutput("in_count", 32'(in_count), 32'(monExp.inCnt));
            checkOutput("out_count", 32'(out_count), 32'(monExp.outCnt));
            checkOutput("in_ready", 32'(in_ready), 32'(monExp.inRdy));
            checkOutput("out_valid", 32'(out_valid), 32'(monExp.outVld));
            checkOutput("out_data_level", out_data, monExp.outData);
            if (monExp.busMode == BUS_VALUE)         checkOutput("data_bus", data_bus, monExp.busVal);
            else if (monExp.busMode == BUS_RELEASED) checkReleased();
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (expOut.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL out_pop: got word %h, expected no word at %0t", out_data, $time);
            end else begin
                checkOutput("out_pop_word", out_data, expOut.pop_front());
            end
        end
    end

    initial begin
        logic [31:0] rAddr;
        logic        rRw;
        logic [31:0] rData;
        int          hold;
        reset       = 1'b1;
        address_bus = 32'h0;
        ram_write   = 1'b0;
        cpuData     = 32'h0;
        cpuDrive    = 1'b0;
        in_data     = 32'h0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        @(posedge clock);
        #1;
        doReset(32'h0);

        // Two pushed words, read by two separate multi-cycle accesses.
        hostPush(32'd5);
        hostPush(32'd7);
        cpuRead(IN_ADDR, 2);
        idle(1);
        cpuRead(IN_ADDR, 2);
        idle(2);

        // Read from an empty input FIFO, then inspect and clear the sticky flags.
        cpuRead(IN_ADDR, 2);
        idle(1);
        cpuRead(STAT_ADDR, 1);
        cpuWrite(STAT_ADDR, 32'h0, 2);
        cpuRead(STAT_ADDR, 1);
        idle(1);

        // Held write strobe pushes once; host pops it.
        cpuWrite(OUT_ADDR, 32'd42, 3);
        idle(1);
        hostPop(1);
        idle(1);

        // Fill, overflow, drain; then write-while-full with a same-edge pop.
        for (int i = 1; i <= DEPTH; i++) begin
            cpuWrite(OUT_ADDR, 32'(i), 1);
            idle(1);
        end
        cpuWrite(OUT_ADDR, 32'd99, 1);
        cpuRead(STAT_ADDR, 1);
        hostPop(DEPTH + 1);
        for (int i = 1; i <= DEPTH; i++) begin
            cpuWrite(OUT_ADDR, 32'(i), 1);
            idle(1);
        end
        applyStimulus(OUT_ADDR, 1'b1, 32'd100, 1'b0, 32'h0, 1'b1);
        idle(1);
        hostPop(DEPTH + 1);

        // Fill the input FIFO, push while full, then read-end coinciding with a push.
        for (int i = 0; i < DEPTH; i++) hostPush(32'h100 + 32'(i));
        hostPush(32'h999);
        cpuRead(IN_ADDR, 1);
        applyStimulus(32'h0, 1'b0, 32'h0, 1'b1, 32'h777, 1'b0);
        cpuRead(IN_ADDR, 1);
        idle(1);
        for (int i = 0; i < DEPTH; i++) begin
            cpuRead(IN_ADDR, 1);
            idle(1);
        end

        // Reset in the middle of a read with both FIFOs populated.
        for (int i = 0; i < 3; i++) begin
            hostPush(32'h200 + 32'(i));
            cpuWrite(OUT_ADDR, 32'h300 + 32'(i), 1);
        end
        idle(1);
        cpuRead(IN_ADDR, 1);
        doReset(IN_ADDR);
        cpuRead(IN_ADDR, 2);
        idle(2);

        hold  = 0;
        rAddr = 32'h0;
        rRw   = 1'b0;
        rData = 32'h0;
        for (int c = 0; c < 800; c++) begin
            if (hold == 0) begin
                case ($urandom_range(0, 8))
                    0, 1:    begin rAddr = IN_ADDR;   rRw = 1'b0; end
                    2, 3:    begin rAddr = OUT_ADDR;  rRw = 1'b1; end
                    4:       begin rAddr = STAT_ADDR; rRw = 1'b0; end
                    5:       begin rAddr = STAT_ADDR; rRw = 1'b1; end
                    6:       begin rAddr = OUT_ADDR;  rRw = 1'b0; end
                    7:       begin rAddr = $urandom;  rRw = 1'($urandom_range(0, 1)); end
                    default: begin rAddr = 32'h0;     rRw = 1'b0; end
                endcase
                rData = $urandom;
                hold  = $urandom_range(1, 3);
            end
            hold--;
            applyStimulus(rAddr, rRw, rData, 1'($urandom_range(0, 1)), $urandom,
                          ($urandom_range(0, 2) == 0));
        end
        idle(2);

        $display("[TB] model sticky flags at end: overflow=%0d underflow=%0d", mdlOver, mdlUnder);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
